au_in_arbiter: RTL and testbench

//  Round-robin burst arbiter that shares the arithmetic-unit (AU) input mux among NUM_SRC requesters.

---
 rtl/au_in_arbiter_pkg.sv | 18 +
 rtl/au_in_arbiter_if.sv | 23 ++
 rtl/au_in_arbiter_rr_pick.sv | 38 +++
 rtl/au_in_arbiter.sv | 108 ++++++++++
 tb/tb_au_in_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/au_in_arbiter_pkg.sv
// Shared sizing, state encoding and one-hot helper for the AU input arbiter.
package au_arb_pkg;

    localparam int NUM_SRC   = 21;
    localparam int SEL_W     = 5;
    localparam int MAX_BURST = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
        return {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/au_in_arbiter_if.sv
// Requester/AU-side signal bundle of the AU input arbiter.
interface au_in_arbiter_if;

    logic [au_arb_pkg::NUM_SRC-1:0] req;
    logic [au_arb_pkg::NUM_SRC-1:0] last;
    logic                           au_ready;
    logic [au_arb_pkg::SEL_W-1:0]   sel;
    logic                           au_valid;
    logic [au_arb_pkg::NUM_SRC-1:0] gnt;
    logic [au_arb_pkg::NUM_SRC-1:0] ack;
    logic                           busy;

    modport master (
        input  req, last, au_ready,
        output sel, au_valid, gnt, ack, busy
    );

    modport slave (
        output req, last, au_ready,
        input  sel, au_valid, gnt, ack, busy
    );

endinterface

// File: rtl/au_in_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping NUM_SRC-1 -> 0.
module rr_pick
    import au_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] cand_s;

    // Scan candidates in priority order; first hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = {SEL_W{1'b0}};
        sum_s  = {(SEL_W+1){1'b0}};
        cand_s = {SEL_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            sum_s = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum_s >= NUM_SRC_W) begin
                cand_s = SEL_W'(sum_s - NUM_SRC_W);
            end else begin
                cand_s = SEL_W'(sum_s);
            end
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/au_in_arbiter.sv
// Round-robin burst arbiter for the AU input mux: picks an owner, streams its
// beats to the AU, and releases on last beat, burst limit, or request drop.
module au_in_arbiter
    import au_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    au_in_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
    localparam logic [SEL_W-1:0] LAST_SRC_C  = SEL_W'(NUM_SRC - 1);

    arb_state_e       state_r, state_next_s;
    logic [SEL_W-1:0] sel_r, sel_next_s;
    logic [SEL_W-1:0] ptr_r, ptr_next_s;
    logic [NUM_SRC-1:0] gnt_r, gnt_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;

    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             owner_req_s;
    logic             au_valid_s;
    logic             accept_s;
    logic             release_s;
    logic [CNT_W-1:0] cnt_inc_s;

    rr_pick u_rr_pick (
        .req   (bus.req),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Handshake toward the AU is combinational so a stall costs no extra cycle.
    assign owner_req_s = bus.req[sel_r];
    assign au_valid_s  = !rst && (state_r == OWN) && owner_req_s;
    assign accept_s    = au_valid_s && bus.au_ready;
    assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign release_s   = (state_r == OWN) &&
                         ((accept_s && (bus.last[sel_r] || (cnt_inc_s == MAX_BURST_C))) ||
                          !owner_req_s);

    assign bus.sel      = sel_r;
    assign bus.gnt      = gnt_r;
    assign bus.au_valid = au_valid_s;
    assign bus.ack      = accept_s ? src_onehot(sel_r) : {NUM_SRC{1'b0}};
    assign bus.busy     = !rst && (state_r == OWN);

    // Next-state logic for the ownership FSM and its counters.
    always_comb begin
        state_next_s = state_r;
        sel_next_s   = sel_r;
        ptr_next_s   = ptr_r;
        gnt_next_s   = gnt_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_next_s = OWN;
                    sel_next_s   = pick_idx_s;
                    gnt_next_s   = src_onehot(pick_idx_s);
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN: begin
                if (accept_s) begin
                    cnt_next_s = cnt_inc_s;
                end else begin
                    cnt_next_s = cnt_r;
                end
                // SEL is kept after release so the mux stays put until the next pick.
                if (release_s) begin
                    state_next_s = IDLE;
                    gnt_next_s   = {NUM_SRC{1'b0}};
                    ptr_next_s   = (sel_r == LAST_SRC_C) ? {SEL_W{1'b0}}
                                                         : sel_r + {{(SEL_W-1){1'b0}}, 1'b1};
                end else begin
                    state_next_s = OWN;
                end
            end
            default: begin
                state_next_s = IDLE;
                gnt_next_s   = {NUM_SRC{1'b0}};
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= {SEL_W{1'b0}};
            ptr_r   <= {SEL_W{1'b0}};
            gnt_r   <= {NUM_SRC{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            sel_r   <= sel_next_s;
            ptr_r   <= ptr_next_s;
            gnt_r   <= gnt_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

endmodule

// File: tb/tb_au_in_arbiter.sv
// Directed bench for au_in_arbiter: vector table plus multi-cycle burst sequences.
module tb_au_in_arbiter;
    import au_arb_pkg::*;

    typedef struct {
        logic [20:0] req;
        logic [20:0] last;
        logic        rdy;
        int          sel;
        logic [20:0] gnt;
        logic        valid;
        logic [20:0] ack;
        logic        busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    au_in_arbiter_if bus();

    au_in_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[6];

    function automatic logic [20:0] oh(input int i);
        logic [20:0] v;
        v = 21'd0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 21'd0;
        bus.last = 21'd0;
        bus.au_ready = 1'b0;
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic expect_idle(input string name);
        #1;
        check({name, " busy"},  32'(bus.busy), 32'd0);
        check({name, " gnt"},   32'(bus.gnt), 32'd0);
        check({name, " valid"}, 32'(bus.au_valid), 32'd0);
        check({name, " ack"},   32'(bus.ack), 32'd0);
        advance();
    endtask

    task automatic expect_own(input string name, input int owner, input bit exp_ack);
        #1;
        check({name, " busy"},  32'(bus.busy), 32'd1);
        check({name, " sel"},   32'(bus.sel), 32'(owner));
        check({name, " gnt"},   32'(bus.gnt), 32'(oh(owner)));
        check({name, " valid"}, 32'(bus.au_valid), 32'd1);
        check({name, " ack"},   32'(bus.ack), exp_ack ? 32'(oh(owner)) : 32'd0);
        advance();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Single-beat grant to 3, then PTR=4 makes 5 win over 3.
        vecs[0] = '{oh(3), oh(3), 1'b1, 0, 21'd0, 1'b0, 21'd0, 1'b0};
        vecs[1] = '{oh(3), oh(3), 1'b1, 3, oh(3), 1'b1, oh(3), 1'b1};
        vecs[2] = '{21'd0, 21'd0, 1'b1, 3, 21'd0, 1'b0, 21'd0, 1'b0};
        vecs[3] = '{oh(3) | oh(5), oh(3) | oh(5), 1'b1, 3, 21'd0, 1'b0, 21'd0, 1'b0};
        vecs[4] = '{oh(3) | oh(5), oh(3) | oh(5), 1'b1, 5, oh(5), 1'b1, oh(5), 1'b1};
        vecs[5] = '{21'd0, 21'd0, 1'b1, 5, 21'd0, 1'b0, 21'd0, 1'b0};

        // Reset state, with requests present during reset.
        bus.req = {21{1'b1}};
        bus.last = 21'd0;
        bus.au_ready = 1'b1;
        rst = 1'b1;
        advance();
        #1;
        check("reset valid", 32'(bus.au_valid), 32'd0);
        check("reset ack",   32'(bus.ack), 32'd0);
        check("reset busy",  32'(bus.busy), 32'd0);
        check("reset sel",   32'(bus.sel), 32'd0);
        check("reset gnt",   32'(bus.gnt), 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            bus.req = vecs[i].req;
            bus.last = vecs[i].last;
            bus.au_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d sel", i),   32'(bus.sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d gnt", i),   32'(bus.gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d valid", i), 32'(bus.au_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d ack", i),   32'(bus.ack), 32'(vecs[i].ack));
            check($sformatf("vec%0d busy", i),  32'(bus.busy), 32'(vecs[i].busy));
            advance();
        end

        // Sources 0 and 20 alternate in full 8-beat bursts, wrapping back to 0.
        do_reset();
        bus.req = oh(0) | oh(20);
        bus.au_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            expect_idle($sformatf("burst%0d turn", b));
            for (int k = 0; k < MAX_BURST; k++)
                expect_own($sformatf("burst%0d beat%0d", b, k), (b == 1) ? 20 : 0, 1'b1);
        end

        // Stall: owner 5 frozen with AU_READY low, then a full 8-beat burst.
        do_reset();
        bus.req = oh(5);
        expect_idle("stall turn");
        for (int k = 0; k < 4; k++) expect_own($sformatf("stall%0d", k), 5, 1'b0);
        bus.au_ready = 1'b1;
        for (int k = 0; k < MAX_BURST; k++) expect_own($sformatf("stall beat%0d", k), 5, 1'b1);
        expect_idle("stall release");

        // Owner 7 drops request after 2 beats; PTR then favours 8.
        do_reset();
        bus.req = oh(7);
        bus.au_ready = 1'b1;
        expect_idle("drop turn");
        expect_own("drop beat0", 7, 1'b1);
        expect_own("drop beat1", 7, 1'b1);
        bus.req = 21'd0;
        #1;
        check("drop busy",  32'(bus.busy), 32'd1);
        check("drop valid", 32'(bus.au_valid), 32'd0);
        check("drop ack",   32'(bus.ack), 32'd0);
        advance();
        bus.req = oh(7) | oh(8);
        expect_idle("drop release");
        expect_own("drop next", 8, 1'b1);

        // Reset mid-burst returns PTR to 0.
        do_reset();
        bus.req = oh(15);
        bus.last = oh(15);
        bus.au_ready = 1'b1;
        expect_idle("mid turn0");
        expect_own("mid src15", 15, 1'b1);
        bus.req = oh(9);
        bus.last = 21'd0;
        expect_idle("mid turn1");
        for (int k = 0; k < 5; k++) expect_own($sformatf("mid beat%0d", k), 9, 1'b1);
        rst = 1'b1;
        #1;
        check("mid rst valid", 32'(bus.au_valid), 32'd0);
        check("mid rst ack",   32'(bus.ack), 32'd0);
        check("mid rst busy",  32'(bus.busy), 32'd0);
        advance();
        rst = 1'b0;
        bus.req = oh(2) | oh(17);
        bus.last = oh(2) | oh(17);
        expect_idle("mid after rst");
        expect_own("mid ptr0 pick", 2, 1'b1);

        // All sources requesting single beats: full rotation then wrap.
        do_reset();
        bus.req = {21{1'b1}};
        bus.last = {21{1'b1}};
        bus.au_ready = 1'b1;
        for (int i = 0; i <= NUM_SRC; i++) begin
            expect_idle($sformatf("rr turn%0d", i));
            expect_own($sformatf("rr grant%0d", i), (i == NUM_SRC) ? 0 : i, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
